// File: rtl/sobel_frame_ctrl.sv
// Frame controller for a streaming Sobel kernel: feeds source pixels into the
// kernel, tags kernel results with row/col, and watches for a stalled kernel.
module sobel_frame_ctrl #(
  parameter int unsigned ROWS       = 360,
  parameter int unsigned COLS       = 480,
  parameter int unsigned OUT_PIXELS = (ROWS - 2) * (COLS - 2),
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       src_valid_i,
  input  logic [7:0] src_data_i,
  output logic       src_ready_o,
  output logic       we_o,
  output logic [7:0] data_o,
  input  logic       done_i,
  input  logic [7:0] grayscale_i,
  output logic       pix_valid_o,
  output logic [7:0] pix_o,
  output logic [8:0] pix_row_o,
  output logic [8:0] pix_col_o,
  output logic       busy_o,
  output logic       frame_done_o,
  output logic       err_o
);

  localparam int unsigned PIXELS = ROWS * COLS;
  localparam int unsigned CNT_W  = $clog2(PIXELS + 1);
  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CRD_W  = 9;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   in_cnt;
  logic [CNT_W-1:0]   out_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic [CRD_W-1:0]   row;
  logic [CRD_W-1:0]   col;
  logic               accept;
  logic               take_result;
  logic               last_result;
  logic               last_pixel;

  // Ready and busy decode straight from the state register.
  assign src_ready_o = (state == FEED);
  assign busy_o      = (state == FEED) || (state == DRAIN);
  assign accept      = src_valid_i & src_ready_o;
  assign take_result = done_i & busy_o;
  assign last_result = take_result && (out_cnt == CNT_W'(OUT_PIXELS - 1));
  assign last_pixel  = accept && (in_cnt == CNT_W'(PIXELS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      in_cnt       <= '0;
      out_cnt      <= '0;
      idle_cnt     <= '0;
      row          <= '0;
      col          <= '0;
      we_o         <= 1'b0;
      data_o       <= '0;
      pix_valid_o  <= 1'b0;
      pix_o        <= '0;
      pix_row_o    <= '0;
      pix_col_o    <= '0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      we_o         <= 1'b0;
      pix_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;

      if (accept) begin
        we_o   <= 1'b1;
        data_o <= src_data_i;
        in_cnt <= in_cnt + CNT_W'(1);
      end

      // Result carries the coordinate held before this result advances it.
      if (take_result) begin
        pix_valid_o <= 1'b1;
        pix_o       <= grayscale_i;
        pix_row_o   <= row;
        pix_col_o   <= col;
        out_cnt     <= out_cnt + CNT_W'(1);
        if (col == CRD_W'(COLS - 3)) begin
          col <= '0;
          row <= row + CRD_W'(1);
        end else begin
          col <= col + CRD_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start_i) begin
            in_cnt   <= '0;
            out_cnt  <= '0;
            idle_cnt <= '0;
            row      <= '0;
            col      <= '0;
            err_o    <= 1'b0;
            state    <= FEED;
          end
        end
        FEED: begin
          if (last_result) begin
            state        <= DONE;
            frame_done_o <= 1'b1;
          end else if (last_pixel) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_result) begin
            state        <= DONE;
            frame_done_o <= 1'b1;
          end else if (done_i) begin
            idle_cnt <= '0;
          end else if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
            err_o        <= 1'b1;
            state        <= DONE;
            frame_done_o <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl on a 4x5 frame with a short timeout.
module tb_sobel_frame_ctrl;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 5;
  localparam int unsigned OUTP = 6;
  localparam int unsigned TO   = 8;
  localparam int unsigned NPIX = ROWS * COLS;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_i = 1'b0;
  logic       src_valid_i = 1'b0;
  logic [7:0] src_data_i = '0;
  logic       src_ready_o;
  logic       we_o;
  logic [7:0] data_o;
  logic       done_i = 1'b0;
  logic [7:0] grayscale_i = '0;
  logic       pix_valid_o;
  logic [7:0] pix_o;
  logic [8:0] pix_row_o;
  logic [8:0] pix_col_o;
  logic       busy_o;
  logic       frame_done_o;
  logic       err_o;

  sobel_frame_ctrl #(.ROWS(ROWS), .COLS(COLS), .OUT_PIXELS(OUTP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_valid_i(src_valid_i),
    .src_data_i(src_data_i), .src_ready_o(src_ready_o), .we_o(we_o), .data_o(data_o),
    .done_i(done_i), .grayscale_i(grayscale_i), .pix_valid_o(pix_valid_o), .pix_o(pix_o),
    .pix_row_o(pix_row_o), .pix_col_o(pix_col_o), .busy_o(busy_o),
    .frame_done_o(frame_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] v; int cyc; } wr_t;
  typedef struct { logic [7:0] v; logic [8:0] r; logic [8:0] c; int cyc; } px_t;

  wr_t wr_q[$];
  px_t px_q[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  we_cnt = 0;
  int  pv_cnt = 0;
  int  fd_cnt = 0;
  int  res_k = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Output monitor: pops scoreboard entries whenever the DUT produces writes or results.
  initial begin
    wr_t        w;
    px_t        p;
    logic [7:0] prev_data;
    bit         prev_ok;
    prev_data = '0;
    prev_ok   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (we_o) begin
          we_cnt++;
          tests++;
          if (wr_q.size() == 0) begin
            fails++;
            $display("FAIL we_unexpected: data_o=%0d at cycle %0d, required no write", data_o, cyc);
          end else begin
            w = wr_q.pop_front();
            if (data_o !== w.v || cyc != w.cyc) begin
              fails++;
              $display("FAIL we_data: data_o=%0d cycle=%0d, required %0d cycle=%0d", data_o, cyc, w.v, w.cyc);
            end
          end
        end else if (prev_ok) begin
          tests++;
          if (data_o !== prev_data) begin
            fails++;
            $display("FAIL data_hold: data_o=%0d, required %0d", data_o, prev_data);
          end
        end
        if (pix_valid_o) begin
          pv_cnt++;
          tests++;
          if (px_q.size() == 0) begin
            fails++;
            $display("FAIL pix_unexpected: pix_o=%0d (%0d,%0d), required no result", pix_o, pix_row_o, pix_col_o);
          end else begin
            p = px_q.pop_front();
            if (pix_o !== p.v || pix_row_o !== p.r || pix_col_o !== p.c || cyc != p.cyc) begin
              fails++;
              $display("FAIL pix_result: pix=%0d (%0d,%0d) cycle=%0d, required %0d (%0d,%0d) cycle=%0d",
                       pix_o, pix_row_o, pix_col_o, cyc, p.v, p.r, p.c, p.cyc);
            end
          end
        end
        if (frame_done_o) fd_cnt++;
      end
      prev_data = data_o;
      prev_ok   = rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    res_k   = 0;
  endtask

  task automatic feed(input int n, input int gap, input int base);
    for (int i = 0; i < n; i++) begin
      src_valid_i = 1'b1;
      src_data_i  = 8'(base + i);
      wr_q.push_back('{v: 8'(base + i), cyc: cyc + 1});
      tick();
      src_valid_i = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic give_done(input int n);
    for (int i = 0; i < n; i++) begin
      done_i      = 1'b1;
      grayscale_i = 8'(160 + res_k * 7);
      px_q.push_back('{v: 8'(160 + res_k * 7), r: 9'(res_k / 3), c: 9'(res_k % 3), cyc: cyc + 1});
      res_k++;
      tick();
      done_i = 1'b0;
    end
  endtask

  task automatic wait_fd(input int budget, output bit ok);
    int base;
    base = fd_cnt;
    ok   = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (fd_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({src_ready_o, we_o, data_o, pix_valid_o, pix_o, pix_row_o, pix_col_o, busy_o, frame_done_o, err_o} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %0h, required 0",
               {src_ready_o, we_o, data_o, pix_valid_o, pix_o, pix_row_o, pix_col_o, busy_o, frame_done_o, err_o});
    end
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    tests++;
    if (busy_o !== 1'b0 || src_ready_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%0b ready=%0b, required 0 0", busy_o, src_ready_o);
    end
  endtask

  task automatic test_nominal(input int gap, input string tag);
    int we0, pv0, fd0;
    bit ok;
    we0 = we_cnt; pv0 = pv_cnt; fd0 = fd_cnt;
    start_frame();
    tests++;
    if (src_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL %s_feed_state: ready=%0b busy=%0b, required 1 1", tag, src_ready_o, busy_o);
    end
    feed(NPIX, gap, 0);
    tests++;
    if (src_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL %s_drain_state: ready=%0b busy=%0b, required 0 1", tag, src_ready_o, busy_o);
    end
    give_done(OUTP);
    wait_fd(20, ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s_frame_done_timeout: frame_done_o not seen, required within 20 cycles", tag);
    end
    tests++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_err: err_o=%0b, required 0", tag, err_o);
    end
    repeat (3) tick();
    tests++;
    if (we_cnt - we0 != NPIX || pv_cnt - pv0 != OUTP || fd_cnt - fd0 != 1 ||
        wr_q.size() != 0 || px_q.size() != 0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL %s_totals: we=%0d pix=%0d fd=%0d wq=%0d pq=%0d busy=%0b, required %0d %0d 1 0 0 0",
               tag, we_cnt - we0, pv_cnt - pv0, fd_cnt - fd0, wr_q.size(), px_q.size(), busy_o, NPIX, OUTP);
    end
  endtask

  task automatic test_timeout();
    int pv0, fd0, n;
    bit ok;
    pv0 = pv_cnt; fd0 = fd_cnt;
    start_frame();
    feed(NPIX, 0, 0);
    give_done(4);
    n = 0;
    while (busy_o && n < 40) begin
      n++;
      tick();
    end
    tests++;
    if (n != TO || err_o !== 1'b1 || frame_done_o !== 1'b1) begin
      fails++;
      $display("FAIL timeout_entry: idle_cycles=%0d err=%0b fd=%0b, required %0d 1 1", n, err_o, frame_done_o, TO);
    end
    repeat (5) tick();
    tests++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || fd_cnt - fd0 != 1 || pv_cnt - pv0 != 4 || px_q.size() != 0) begin
      fails++;
      $display("FAIL timeout_sticky: err=%0b busy=%0b fd=%0d pix=%0d pq=%0d, required 1 0 1 4 0",
               err_o, busy_o, fd_cnt - fd0, pv_cnt - pv0, px_q.size());
    end
    start_frame();
    tests++;
    if (err_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_err_clear: err_o=%0b, required 0", err_o);
    end
    feed(NPIX, 0, 0);
    give_done(OUTP);
    wait_fd(20, ok);
    tests++;
    if (!ok || err_o !== 1'b0) begin
      fails++;
      $display("FAIL timeout_recover: frame_done_seen=%0b err=%0b, required 1 0", ok, err_o);
    end
    repeat (2) tick();
  endtask

  task automatic test_ignored();
    int pv0;
    bit ok;
    pv0 = pv_cnt;
    done_i = 1'b1;
    grayscale_i = 8'h55;
    repeat (3) tick();
    done_i = 1'b0;
    tick();
    tests++;
    if (pv_cnt != pv0 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL idle_done_ignored: pix=%0d busy=%0b, required 0 0", pv_cnt - pv0, busy_o);
    end
    start_i = 1'b1;
    done_i  = 1'b1;
    tick();
    start_i = 1'b0;
    done_i  = 1'b0;
    res_k   = 0;
    feed(5, 0, 0);
    start_i = 1'b1;
    feed(1, 0, 5);
    start_i = 1'b0;
    feed(NPIX - 6, 0, 6);
    tests++;
    if (src_ready_o !== 1'b0 || busy_o !== 1'b1) begin
      fails++;
      $display("FAIL feed_start_ignored: ready=%0b busy=%0b, required 0 1", src_ready_o, busy_o);
    end
    give_done(OUTP);
    wait_fd(20, ok);
    repeat (2) tick();
    tests++;
    if (!ok || pv_cnt - pv0 != OUTP || px_q.size() != 0 || wr_q.size() != 0) begin
      fails++;
      $display("FAIL ignored_frame: fd_seen=%0b pix=%0d pq=%0d wq=%0d, required 1 %0d 0 0",
               ok, pv_cnt - pv0, px_q.size(), wr_q.size(), OUTP);
    end
  endtask

  task automatic test_reset_mid();
    int fd0;
    fd0 = fd_cnt;
    start_frame();
    feed(10, 0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if ({src_ready_o, we_o, data_o, pix_valid_o, pix_o, pix_row_o, pix_col_o, busy_o, frame_done_o, err_o} !== '0
        || wr_q.size() != 0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %0h wq=%0d, required 0 0",
               {src_ready_o, we_o, data_o, pix_valid_o, pix_o, pix_row_o, pix_col_o, busy_o, frame_done_o, err_o},
               wr_q.size());
    end
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    tests++;
    if (busy_o !== 1'b0 || fd_cnt != fd0) begin
      fails++;
      $display("FAIL mid_reset_abort: busy=%0b fd=%0d, required 0 0", busy_o, fd_cnt - fd0);
    end
  endtask

  task automatic test_early();
    int we0, pv0, fd0;
    we0 = we_cnt; pv0 = pv_cnt; fd0 = fd_cnt;
    start_frame();
    for (int i = 0; i < int'(OUTP); i++) begin
      src_valid_i = 1'b1;
      src_data_i  = 8'(i);
      wr_q.push_back('{v: 8'(i), cyc: cyc + 1});
      done_i      = 1'b1;
      grayscale_i = 8'(160 + res_k * 7);
      px_q.push_back('{v: 8'(160 + res_k * 7), r: 9'(res_k / 3), c: 9'(res_k % 3), cyc: cyc + 1});
      res_k++;
      tick();
    end
    done_i = 1'b0;
    tests++;
    if (src_ready_o !== 1'b0 || busy_o !== 1'b0 || frame_done_o !== 1'b1) begin
      fails++;
      $display("FAIL early_done_entry: ready=%0b busy=%0b fd=%0b, required 0 0 1", src_ready_o, busy_o, frame_done_o);
    end
    src_data_i = 8'hEE;
    repeat (3) tick();
    src_valid_i = 1'b0;
    tests++;
    if (we_cnt - we0 != OUTP || pv_cnt - pv0 != OUTP || fd_cnt - fd0 != 1 || busy_o !== 1'b0 ||
        wr_q.size() != 0 || px_q.size() != 0) begin
      fails++;
      $display("FAIL early_totals: we=%0d pix=%0d fd=%0d busy=%0b wq=%0d pq=%0d, required %0d %0d 1 0 0 0",
               we_cnt - we0, pv_cnt - pv0, fd_cnt - fd0, busy_o, wr_q.size(), px_q.size(), OUTP, OUTP);
    end
  endtask

  initial begin
    test_reset();
    test_nominal(0, "nominal");
    test_nominal(2, "stall");
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_nominal(0, "post_reset");
    test_early();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 Parameter ROWS, default 360, frame height in pixels.
REQ-002 Parameter COLS, default 480, frame width in pixels.
REQ-003 Parameter OUT_PIXELS, default (ROWS-2)*(COLS-2), number of kernel results expected per frame.
REQ-004 Parameter TIMEOUT, default 4096, maximum idle cycles allowed in DRAIN while waiting for a kernel result.
REQ-005 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, reset; asynchronous and active-low.
REQ-007 Port start_i, input, 1, single-cycle frame start request.
REQ-008 Port src_valid_i, input, 1, source pixel valid.
REQ-009 Port src_data_i, input, 8, source grayscale pixel.
REQ-010 Port src_ready_o, output, 1, controller accepts a source pixel this cycle.
REQ-011 Port we_o, output, 1, write enable to the Sobel kernel.
REQ-012 Port data_o, output, 8, pixel to the Sobel kernel.
REQ-013 Port done_i, input, 1, kernel result strobe.
REQ-014 Port grayscale_i, input, 8, kernel result value.
REQ-015 Port pix_valid_o, output, 1, result pixel valid.
REQ-016 Port pix_o, output, 8, result pixel.
REQ-017 Port pix_row_o, output, 9, row of the result pixel, 0..ROWS-3.
REQ-018 Port pix_col_o, output, 9, column of the result pixel, 0..COLS-3.
REQ-019 Port busy_o, output, 1, high in FEED and DRAIN.
REQ-020 Port frame_done_o, output, 1, one-cycle end-of-frame pulse.
REQ-021 Port err_o, output, 1, timeout flag; sticky until the next accepted start.

Function
REQ-022 FSM states: IDLE, FEED, DRAIN, DONE.
REQ-023 IDLE: src_ready_o=0 and we_o=0; start_i=1 clears in_cnt, out_cnt, idle_cnt, row/col and err_o, then moves to FEED.
REQ-024 FEED: src_ready_o=1 combinationally.
REQ-025 Accept = src_valid_i & src_ready_o; an accept registers data_o<=src_data_i and drives we_o=1 for one cycle, giving 1-cycle latency.
REQ-026 When no accept occurs, we_o=0 next cycle, data_o holds, and the kernel stalls.
REQ-027 The accept with in_cnt==ROWS*COLS-1 moves the FSM to DRAIN, and src_ready_o=0 from the following cycle.
REQ-028 In FEED and DRAIN, done_i=1 registers pix_o<=grayscale_i and sets pix_valid_o=1 one cycle later, carrying the current row/col, then increments out_cnt.
REQ-029 Coordinate update: col increments per result and wraps at COLS-3 to 0, incrementing row at the wrap.
REQ-030 Reaching out_cnt==OUT_PIXELS (the result that makes it equal) moves the FSM to DONE from FEED or DRAIN.
REQ-031 DRAIN: idle_cnt increments on each cycle without done_i and clears on done_i; idle_cnt reaching TIMEOUT-1 sets err_o=1 and moves the FSM to DONE.
REQ-032 DONE: frame_done_o=1 for exactly one cycle, then return to IDLE.
REQ-033 done_i in IDLE or DONE is ignored: no pix_valid_o and no count change.
REQ-034 start_i outside IDLE is ignored.
REQ-035 If start_i and done_i occur in the same IDLE cycle, start is taken and done_i is ignored.
REQ-036 Counters are sized to hold ROWS*COLS and TIMEOUT without wrap.

Reset
REQ-037 While rst=0, asynchronously: state=IDLE, and all outputs 0 (src_ready_o, we_o, data_o, pix_valid_o, pix_o, pix_row_o, pix_col_o, busy_o, frame_done_o, err_o).
REQ-038 While rst=0, all counters are 0.
REQ-039 Reset asserted mid-frame aborts the frame with no frame_done_o; after release the block waits for a new start_i.

Verification (ROWS=4, COLS=5, OUT_PIXELS=6, TIMEOUT=8)
REQ-040 Nominal frame: start, then 20 back-to-back valid pixels 0..19, then the kernel model returns 6 done_i -> exactly 20 we_o pulses with data_o 0..19 at 1-cycle latency; 6 pix_valid_o at (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); one frame_done_o; err_o=0.
REQ-041 Source stalls: src_valid_i toggles 1,0,0,1,... -> we_o pulses only on accept cycles, data_o holds between them, and the total is still 20.
REQ-042 Timeout: only 4 done_i are returned after the last pixel -> 8 idle cycles later err_o=1, one frame_done_o, state IDLE, and err_o holds until the next start.
REQ-043 Ignored events: start_i pulsed during FEED, and done_i in IDLE -> no counter, state or output change.
REQ-044 Reset mid-FEED after 10 pixels -> all outputs 0 immediately, no frame_done_o; a following full frame behaves as in REQ-040.
REQ-045 Early completion: 6 done_i arrive before the 20th pixel -> DONE is entered from FEED, src_ready_o drops, and one frame_done_o is produced.
